// File: rtl/keyboard_event_queue.sv
// Key-change scanner: visits one key index per cycle and queues press/release events.
// Latency: an event pushed at edge t is on event_valid/event_data after edge t+1.
// Backpressure: a full queue defers the key to a later sweep; no event is ever dropped.
//
// Ports:
//   clock, reset_n              single rising-edge clock, async active-low reset
//   row_sync, key_down          snapshot strobe and debounced key matrix (1 = pressed)
//   event_data/valid/ready      {new_state, key_index} event stream, valid/ready handshake
//   event_level                 current queue occupancy
//
// Optional build macro: KEYBOARD_EVENT_DEBOUNCE_EN -- a change must be seen on two
// consecutive visits of the same key before it is reported.

// Small generic FIFO with a registered head. The head register is loaded from the
// storage array one edge after a write into an empty FIFO (no fall-through), and the
// next entry is loaded on the pop edge so back-to-back pops stream at one per cycle.
// Full is judged on pre-edge occupancy, so a same-cycle pop never frees room for a push.
module keyboard_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    output logic                   full,
    output logic                   head_vld,
    output logic [WIDTH-1:0]       head_dat,
    input  logic                   head_rdy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_inc;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop;
    logic             head_vld_nxt;
    logic [WIDTH-1:0] head_dat_nxt;

    assign full       = (count == CW'(DEPTH));
    assign push_ok    = push_vld & ~full;
    assign pop        = head_vld & head_rdy;
    assign rd_ptr_inc = rd_ptr + AW'(1);
    assign level      = count;

    // The head register mirrors mem[rd_ptr] whenever it is valid. On a pop the
    // entry behind the head moves up; an entry written this very edge is not
    // visible yet, which is why occupancy is compared with 1 rather than 0.
    always_comb begin
        head_vld_nxt = 1'b0;
        head_dat_nxt = '0;
        if (pop) begin
            head_vld_nxt = (count > CW'(1));
            if (count > CW'(1)) begin
                head_dat_nxt = mem[rd_ptr_inc];
            end
        end else begin
            head_vld_nxt = (count != '0);
            if (count != '0) begin
                head_dat_nxt = mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_vld <= 1'b0;
            head_dat <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count    <= count + CW'(push_ok) - CW'(pop);
            head_vld <= head_vld_nxt;
            head_dat <= head_dat_nxt;
        end
    end
endmodule

module keyboard_event_queue #(
    parameter int NUM_KEYS   = 103,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          row_sync,
    input  logic [NUM_KEYS-1:0]           key_down,
    output logic [$clog2(NUM_KEYS):0]     event_data,
    output logic                          event_valid,
    input  logic                          event_ready,
    output logic [$clog2(FIFO_DEPTH):0]   event_level
);
    localparam int ID_W = $clog2(NUM_KEYS);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_KEYS - 1);

    logic [NUM_KEYS-1:0] snap;       // matrix as captured on the last row_sync
    logic [NUM_KEYS-1:0] rep;        // state last handed to the consumer, per key
    logic [ID_W-1:0]     cnt;        // key index visited this cycle
    logic                cur_snap;
    logic                mismatch;
    logic                qualified;
    logic                fifo_full;
    logic                push;

    assign cur_snap = snap[cnt];
    assign mismatch = cur_snap ^ rep[cnt];

    // rep only moves when the event actually enters the queue; a rejected push
    // leaves the mismatch in place so the next sweep retries it.
    assign push = mismatch & qualified & ~fifo_full;

`ifdef KEYBOARD_EVENT_DEBOUNCE_EN
    logic [NUM_KEYS-1:0] pend;       // mismatch already seen on the previous visit

    assign qualified = pend[cnt];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else if (!mismatch) begin
            pend[cnt] <= 1'b0;
        end else if (!pend[cnt]) begin
            pend[cnt] <= 1'b1;
        end else if (push) begin
            pend[cnt] <= 1'b0;
        end
        // mismatch with pend set but queue full: keep pend so the retry qualifies
    end
`else
    assign qualified = 1'b1;
`endif

    // The counter free-runs; it is never stalled by a full queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            snap <= '0;
            rep  <= '0;
        end else begin
            cnt <= (cnt == LAST_IDX) ? '0 : cnt + ID_W'(1);
            if (row_sync) begin
                snap <= key_down;
            end
            if (push) begin
                rep[cnt] <= cur_snap;
            end
        end
    end

    keyboard_event_fifo #(
        .WIDTH (ID_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push_vld (push),
        .push_dat ({cur_snap, cnt}),
        .full     (fifo_full),
        .head_vld (event_valid),
        .head_dat (event_data),
        .head_rdy (event_ready),
        .level    (event_level)
    );
endmodule

// File: tb/tb_keyboard_event_queue.sv
module tb_keyboard_event_queue;
    localparam int NK  = 103;
    localparam int FD  = 4;
    localparam int IDW = $clog2(NK);
    localparam int LW  = $clog2(FD) + 1;
`ifdef KEYBOARD_EVENT_DEBOUNCE_EN
    localparam int SWEEPS = 2;
`else
    localparam int SWEEPS = 1;
`endif

    logic            clock       = 1'b0;
    logic            reset_n     = 1'b0;
    logic            row_sync    = 1'b0;
    logic            event_ready = 1'b0;
    logic [NK-1:0]   key_down    = '0;
    logic [IDW:0]    event_data;
    logic            event_valid;
    logic [LW-1:0]   event_level;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c0       = 0;       // cyc value just before the first edge after reset release
    int first_seen;
    logic [IDW:0] got[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    keyboard_event_queue #(
        .NUM_KEYS   (NK),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .row_sync    (row_sync),
        .key_down    (key_down),
        .event_data  (event_data),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_level (event_level)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Edge number k (counted from reset release) visits key (k-1) mod NK.
    function automatic int next_visit(input int from, input int idx);
        int k;
        k = from;
        while (((k - 1) % NK) != idx) k++;
        return k;
    endfunction

    // Runs n edges, records every accepted event; row_sync is a one-cycle strobe.
    task automatic collect(input int n);
        first_seen = -1;
        for (int c = 0; c < n; c++) begin
            if (event_valid && event_ready) got.push_back(event_data);
            tick();
            row_sync = 1'b0;
            if (event_valid && first_seen < 0) first_seen = cyc - c0;
        end
    endtask

    task automatic do_reset(input logic [NK-1:0] kd);
        reset_n  = 1'b0;
        row_sync = 1'b0;
        key_down = kd;
        repeat (3) tick();
        reset_n = 1'b1;
        c0 = cyc;
    endtask

    task automatic test_reset();
        logic [NK-1:0] kd;
        int bad;
        reset_n = 1'b0;
        event_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NK; i++) kd[i] = 1'($urandom & 1);
            key_down = kd;
            row_sync = 1'b1;
            tick();
            n_checks++;
            if (event_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", event_valid); end
            n_checks++;
            if (event_level !== '0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", event_level); end
            n_checks++;
            if (event_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=00", event_data); end
        end
        row_sync = 1'b0;
        key_down = '0;
        event_ready = 1'b1;
        reset_n = 1'b1;
        c0 = cyc;
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (event_valid !== 1'b0 || event_level !== '0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL reset_quiet bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_single();
        int j, kp;
        logic [IDW:0] e0;
        event_ready = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            key_down = '0;
            key_down[5] = (ph == 0);
            e0 = (ph == 0) ? 8'h85 : 8'h05;
            j = cyc - c0;
            kp = next_visit(j + 2, 5) + (SWEEPS - 1) * NK;
            got.delete();
            row_sync = 1'b1;
            collect(SWEEPS * NK + 12);
            n_checks++;
            if (got.size() != 1) begin n_fail++; $display("FAIL single_count ph=%0d got=%0d exp=1", ph, got.size()); end
            n_checks++;
            if (got.size() < 1 || got[0] !== e0) begin
                n_fail++; $display("FAIL single_data ph=%0d got=%h exp=%h", ph, (got.size() > 0) ? got[0] : 8'hxx, e0);
            end
            n_checks++;
            if (first_seen != kp + 1) begin
                n_fail++; $display("FAIL single_latency ph=%0d got_edge=%0d exp_edge=%0d", ph, first_seen, kp + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [IDW:0] e;
        event_ready = 1'b0;
        key_down = '0;
        key_down[9:0] = 10'h3FF;
        row_sync = 1'b1;
        tick();
        row_sync = 1'b0;
        repeat (SWEEPS * NK + 15) tick();
        n_checks++;
        if (event_level !== LW'(4)) begin n_fail++; $display("FAIL bp_level got=%0d exp=4", event_level); end
        n_checks++;
        if (event_valid !== 1'b1 || event_data !== 8'h80) begin
            n_fail++; $display("FAIL bp_head got_v=%b got_d=%h exp_v=1 exp_d=80", event_valid, event_data);
        end
        repeat (7) tick();
        n_checks++;
        if (event_data !== 8'h80 || event_level !== LW'(4)) begin
            n_fail++; $display("FAIL bp_stable got_d=%h got_l=%0d exp_d=80 exp_l=4", event_data, event_level);
        end
        got.delete();
        event_ready = 1'b1;
        collect(2 * NK + 20);
        n_checks++;
        if (got.size() != 10) begin n_fail++; $display("FAIL bp_count got=%0d exp=10", got.size()); end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            e = {1'b1, IDW'(i)};
            n_checks++;
            if (got[i] !== e) begin n_fail++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], e); end
        end
        n_checks++;
        if (event_level !== '0 || event_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drained got_l=%0d got_v=%b exp=0", event_level, event_valid);
        end
    endtask

    task automatic test_full_pop();
        bit hit;
        logic [IDW:0] exp_q[$];
        event_ready = 1'b0;
        key_down[24:20] = 5'h1F;
        row_sync = 1'b1;
        tick();
        row_sync = 1'b0;
        hit = 0;
        for (int c = 0; c < SWEEPS * NK + 40; c++) begin
            tick();
            if (event_level == LW'(4)) begin hit = 1; break; end
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL fp_fill got_l=%0d exp=4", event_level); return; end
        n_checks++;
        if (((cyc - c0) % NK) != 24) begin
            n_fail++; $display("FAIL fp_phase got_next_idx=%0d exp=24", (cyc - c0) % NK);
        end
        n_checks++;
        if (event_data !== 8'h94) begin n_fail++; $display("FAIL fp_head got=%h exp=94", event_data); end
        event_ready = 1'b1;          // pop on the very edge key 24 is revisited
        tick();
        event_ready = 1'b0;
        n_checks++;
        if (event_level !== LW'(3)) begin n_fail++; $display("FAIL fp_no_push got=%0d exp=3", event_level); end
        repeat (NK - 1) tick();
        n_checks++;
        if (event_level !== LW'(3)) begin n_fail++; $display("FAIL fp_hold got=%0d exp=3", event_level); end
        tick();
        n_checks++;
        if (event_level !== LW'(4)) begin n_fail++; $display("FAIL fp_retry got=%0d exp=4", event_level); end
        got.delete();
        event_ready = 1'b1;
        collect(20);
        exp_q = '{8'h95, 8'h96, 8'h97, 8'h98};
        n_checks++;
        if (got != exp_q) begin n_fail++; $display("FAIL fp_drain got=%p exp=%p", got, exp_q); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        int j, k;
        logic [IDW:0] exp_q[$];
        event_ready = 1'b0;
        key_down[42:40] = 3'b111;
        row_sync = 1'b1;
        tick();
        row_sync = 1'b0;
        hit = 0;
        for (int c = 0; c < SWEEPS * NK + 20; c++) begin
            tick();
            if (event_level == LW'(3)) begin hit = 1; break; end
        end
        repeat (3) tick();
        n_checks++;
        if (!hit || event_level !== LW'(3) || event_valid !== 1'b1) begin
            n_fail++; $display("FAIL rm_queued got_l=%0d got_v=%b exp_l=3 exp_v=1", event_level, event_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (event_valid !== 1'b0 || event_level !== '0 || event_data !== '0) begin
            n_fail++; $display("FAIL rm_async got_v=%b got_l=%0d got_d=%h exp=0", event_valid, event_level, event_data);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        c0 = cyc;
        event_ready = 1'b1;
        j = cyc - c0;
        for (int v = 0; v < NK; v++) begin
            k = (j + 2 + v - 1) % NK;
            if (key_down[k]) exp_q.push_back({1'b1, IDW'(k)});
        end
        got.delete();
        row_sync = 1'b1;
        collect(SWEEPS * NK + 20);
        n_checks++;
        if (got != exp_q) begin n_fail++; $display("FAIL rm_regen got_n=%0d exp_n=%0d", got.size(), exp_q.size()); end
    endtask

    task automatic test_debounce_glitch();
        int j, k1;
        logic [IDW:0] exp_q[$];
        do_reset('0);
        event_ready = 1'b1;
        key_down[7] = 1'b1;
        j = cyc - c0;
        k1 = next_visit(j + 2, 7);
        got.delete();
        row_sync = 1'b1;
        collect(k1 + 50 - (j + 1));
        key_down[7] = 1'b0;
        row_sync = 1'b1;
        collect(2 * NK + 20);
`ifdef KEYBOARD_EVENT_DEBOUNCE_EN
        exp_q = {};
`else
        exp_q = '{8'h87, 8'h07};
`endif
        n_checks++;
        if (got != exp_q) begin n_fail++; $display("FAIL glitch got=%p exp=%p", got, exp_q); end
        got.delete();
        key_down[7] = 1'b1;
        row_sync = 1'b1;
        collect(2 * NK + 20);
        exp_q = '{8'h87};
        n_checks++;
        if (got != exp_q) begin n_fail++; $display("FAIL glitch_hold got=%p exp=%p", got, exp_q); end
    endtask

    // Consumer-side model: each accepted event must flip that key's reported state;
    // once the matrix is left alone long enough the reported state equals key_down.
    task automatic test_random();
        logic [NK-1:0] mrep;
        logic pv, pr;
        logic [IDW:0] pd;
        int key, nflip, tot;
        do_reset('0);
        mrep = '0;
        tot = 3000 + (SWEEPS + 1) * NK + 20;
        for (int c = 0; c < tot; c++) begin
            if (c < 3000) begin
                if ($urandom_range(0, 15) == 0) begin
                    nflip = $urandom_range(1, 3);
                    for (int f = 0; f < nflip; f++) begin
                        key = $urandom_range(0, NK - 1);
                        key_down[key] = ~key_down[key];
                    end
                    row_sync = 1'b1;
                end
                event_ready = ($urandom_range(0, 2) != 0);
            end else if (c == 3000) begin
                row_sync = 1'b1;
                event_ready = 1'b1;
            end
            pv = event_valid; pr = event_ready; pd = event_data;
            if (pv && pr) begin
                key = int'(pd[IDW-1:0]);
                n_checks++;
                if (key >= NK || pd[IDW] === mrep[key]) begin
                    n_fail++; $display("FAIL rnd_event cyc=%0d got=%h rep_state=%b", c, pd, (key < NK) ? mrep[key] : 1'bx);
                end else begin
                    mrep[key] = pd[IDW];
                end
            end
            tick();
            row_sync = 1'b0;
            if (pv && !pr) begin
                n_checks++;
                if (event_valid !== 1'b1 || event_data !== pd) begin
                    n_fail++; $display("FAIL rnd_stall cyc=%0d got_v=%b got_d=%h exp_d=%h", c, event_valid, event_data, pd);
                end
            end
            n_checks++;
            if (event_level > LW'(FD) || (event_valid && event_level == '0)) begin
                n_fail++; $display("FAIL rnd_level cyc=%0d got_l=%0d got_v=%b", c, event_level, event_valid);
            end
        end
        n_checks++;
        if (mrep !== key_down) begin n_fail++; $display("FAIL rnd_final got=%h exp=%h", mrep, key_down); end
        n_checks++;
        if (event_level !== '0 || event_valid !== 1'b0) begin
            n_fail++; $display("FAIL rnd_empty got_l=%0d got_v=%b exp=0", event_level, event_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        test_debounce_glitch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
